// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM states,
// the x0 register constant and the per-stage control bundle.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic bubble_idex;
    logic bubble_exmem;
    logic flush_ifid;
    logic mc_busy;
  } stage_ctrl_t;

endpackage

// File: rtl/hazard_stall_controller_perf.sv
// Optional event counters for the hazard controller (load-use stall
// cycles, multi-cycle stall cycles, redirect flushes); wrap at 2^CNT_W.
module hazard_perf_counters
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ev_loaduse,
  input  logic             ev_mc,
  input  logic             ev_flush,
  output logic [CNT_W-1:0] perf_loaduse_cnt,
  output logic [CNT_W-1:0] perf_mc_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loaduse_cnt <= '0;
      perf_mc_cnt      <= '0;
      perf_flush_cnt   <= '0;
    end else begin
      if (ev_loaduse) perf_loaduse_cnt <= perf_loaduse_cnt + 1'b1;
      if (ev_mc)      perf_mc_cnt      <= perf_mc_cnt + 1'b1;
      if (ev_flush)   perf_flush_cnt   <= perf_flush_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/bubble/flush sequencing for the 5-stage core: load-use, mul/div
// occupancy, redirects and imem wait states. HAZARD_PERF_CNT_EN adds counters.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_mc_start,
  input  logic       ex_redirect,
  input  logic       imem_ready,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       stall_idex,
  output logic       bubble_idex,
  output logic       bubble_exmem,
  output logic       flush_ifid,
  output logic       mc_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_loaduse_cnt,
  output logic [CNT_W-1:0] perf_mc_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  localparam int             CW      = $clog2(MC_LATENCY + 1);
  localparam logic [CW-1:0]  MC_INIT = CW'(MC_LATENCY - 2);
  localparam bit             PARAM_OK = (MC_LATENCY >= 2) && (MC_LATENCY <= 32) && (CNT_W >= 1);

  hz_state_e   state;
  logic [CW-1:0] mc_cnt;
  stage_ctrl_t ctrl;
  logic        load_use;

  assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

  // mc_start overrides everything else so stall_idex never meets bubble_idex.
  always_comb begin
    ctrl = '0;
    if (state == RUN) begin
      if (ex_mc_start) begin
        ctrl.stall_pc     = 1'b1;
        ctrl.stall_ifid   = 1'b1;
        ctrl.stall_idex   = 1'b1;
        ctrl.bubble_exmem = 1'b1;
      end else if (ex_redirect) begin
        ctrl.flush_ifid  = 1'b1;
        ctrl.bubble_idex = 1'b1;
      end else if (load_use || !imem_ready) begin
        ctrl.stall_pc    = 1'b1;
        ctrl.stall_ifid  = 1'b1;
        ctrl.bubble_idex = 1'b1;
      end
    end else begin
      ctrl.mc_busy = 1'b1;
      if (mc_cnt != '0) begin
        ctrl.stall_pc     = 1'b1;
        ctrl.stall_ifid   = 1'b1;
        ctrl.stall_idex   = 1'b1;
        ctrl.bubble_exmem = 1'b1;
      end
    end
  end

  // Outputs are forced low for the whole reset assertion, not just at the edge.
  assign stall_pc     = rst_n & ctrl.stall_pc;
  assign stall_ifid   = rst_n & ctrl.stall_ifid;
  assign stall_idex   = rst_n & ctrl.stall_idex;
  assign bubble_idex  = rst_n & ctrl.bubble_idex;
  assign bubble_exmem = rst_n & ctrl.bubble_exmem;
  assign flush_ifid   = rst_n & ctrl.flush_ifid;
  assign mc_busy      = rst_n & ctrl.mc_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      case (state)
        RUN: if (ex_mc_start) begin
          state  <= MC_BUSY;
          mc_cnt <= MC_INIT;
        end
        MC_BUSY: begin
          if (mc_cnt == '0) state <= RUN;
          else              mc_cnt <= mc_cnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  a_param_ok: assert property (@(posedge clk) PARAM_OK);
  a_no_mc_redirect: assert property (@(posedge clk) disable iff (!rst_n)
    !(state == RUN && ex_mc_start && ex_redirect));

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk              (clk),
    .rst_n            (rst_n),
    .ev_loaduse       (state == RUN && !ex_mc_start && !ex_redirect && load_use),
    .ev_mc            (ctrl.stall_idex),
    .ev_flush         (ctrl.flush_ifid),
    .perf_loaduse_cnt (perf_loaduse_cnt),
    .perf_mc_cnt      (perf_mc_cnt),
    .perf_flush_cnt   (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed + randomized bench for hazard_stall_controller against a
// cycle-index reference model of the stall/bubble/flush rules.
module tb_hazard_stall_controller;

  localparam int L     = 4;
  localparam int CNT_W = 32;

  logic       clk, rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_mc_start, ex_redirect, imem_ready;
  logic       stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem, flush_ifid, mc_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_loaduse_cnt, perf_mc_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model: op_idx = which EX cycle (2..L) of a multi-cycle op we are in, 0 if none.
  int op_idx = 0;
  int m_lu = 0, m_mc = 0, m_fl = 0;

  hazard_stall_controller #(.MC_LATENCY(L), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mc_start(ex_mc_start),
    .ex_redirect(ex_redirect), .imem_ready(imem_ready),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .bubble_idex(bubble_idex), .bubble_exmem(bubble_exmem), .flush_ifid(flush_ifid),
    .mc_busy(mc_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_loaduse_cnt(perf_loaduse_cnt), .perf_mc_cnt(perf_mc_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic lu_hit();
    return ex_mem_read && ex_rd != 5'd0 &&
           ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
  endfunction

  // {stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem, flush_ifid, mc_busy}
  function automatic logic [6:0] model_out();
    if (!rst_n)            return 7'b0000000;
    if (op_idx != 0)       return (op_idx < L) ? 7'b1110101 : 7'b0000001;
    if (ex_mc_start)       return 7'b1110100;
    if (ex_redirect)       return 7'b0001010;
    if (lu_hit() || !imem_ready) return 7'b1101000;
    return 7'b0000000;
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic mc, input logic rdr, input logic im);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_mc_start = mc; ex_redirect = rdr; imem_ready = im;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Called just after a negedge: check outputs, advance model at posedge, return at negedge.
  task automatic tick(input string tag);
    logic [6:0] obs, exp;
    #1;
    if (!rst_n) begin
      op_idx = 0; m_lu = 0; m_mc = 0; m_fl = 0;
    end
    exp = model_out();
    obs = {stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem, flush_ifid, mc_busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: ctrl got %b expected %b", tag, obs, exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert ({perf_loaduse_cnt, perf_mc_cnt, perf_flush_cnt} ===
            {CNT_W'(m_lu), CNT_W'(m_mc), CNT_W'(m_fl)}) else begin
      errors++;
      $error("FAIL %s_perf: got %0d/%0d/%0d expected %0d/%0d/%0d", tag,
             perf_loaduse_cnt, perf_mc_cnt, perf_flush_cnt, m_lu, m_mc, m_fl);
    end
`endif
    @(posedge clk);
    if (rst_n) begin
      if (exp[4]) m_mc++;
      if (exp[1]) m_fl++;
      if (op_idx == 0 && !ex_mc_start && !ex_redirect && lu_hit()) m_lu++;
      if (op_idx != 0)      op_idx = (op_idx == L) ? 0 : op_idx + 1;
      else if (ex_mc_start) op_idx = 2;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    tick("reset");
    rst_n = 1'b1;
    idle(); tick("idle");

    set_in(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1); tick("loaduse");
    idle(); tick("loaduse_after");
    set_in(5'd1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1); tick("loaduse_x0");
    set_in(5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1); tick("loaduse_nouse");
    set_in(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1); tick("loaduse_rs1");

    idle(); ex_mc_start = 1'b1; tick("mc_c1");
    idle(); tick("mc_c2"); tick("mc_c3"); tick("mc_c4"); tick("mc_c5_run");

    set_in(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1); tick("redir_lu");

    idle(); ex_mc_start = 1'b1; tick("mc2_c1");
    idle(); ex_redirect = 1'b1; tick("mc2_c2_redir_ignored");
    rst_n = 1'b0; idle(); tick("mc2_reset");
    rst_n = 1'b1; tick("post_reset_run");
    ex_mc_start = 1'b1; tick("mc3_c1");
    idle(); set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); tick("mc3_c2_ignore");
    idle(); tick("mc3_c3"); tick("mc3_c4"); tick("mc3_c5");

    idle(); imem_ready = 1'b0; tick("imem_w1"); tick("imem_w2"); tick("imem_w3");
    idle(); tick("imem_done");
    idle(); imem_ready = 1'b0; ex_redirect = 1'b1; tick("imem_redir");
    set_in(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); tick("imem_lu");

    for (int i = 0; i < 500; i++) begin
      logic mc, rdr;
      mc  = ($urandom_range(0, 99) < 8);
      rdr = !mc && ($urandom_range(0, 99) < 12);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 45),
             mc, rdr, ($urandom_range(0, 99) < 80));
      rst_n = ($urandom_range(0, 99) != 0);
      tick("random");
    end
    rst_n = 1'b1; idle(); tick("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage RV32 core. It sits beside the EX-stage operand-forwarding logic and covers the cases forwarding cannot resolve:
- load-use hazards
- multi-cycle EX operations (mul/div)
- taken-branch/jump redirects
- instruction-memory wait states

It produces per-stage stall, bubble and flush controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers and the PC.

Parameters:
- MC_LATENCY, 4: EX cycles a multi-cycle op occupies, including its issue cycle; legal range 2..32.
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  source register 1 of instruction in ID.
- id_rs2  in  5  source register 2 of instruction in ID.
- id_use_rs1  in  1  ID instruction actually reads rs1.
- id_use_rs2  in  1  ID instruction actually reads rs2.
- ex_rd  in  5  destination of instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_mc_start  in  1  EX instruction is a multi-cycle op (first EX cycle).
- ex_redirect  in  1  EX resolved a taken branch/jump.
- imem_ready  in  1  instruction fetch data valid this cycle.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID register.
- stall_idex  out  1  hold ID/EX register.
- bubble_idex  out  1  load NOP into ID/EX.
- bubble_exmem  out  1  load NOP into EX/MEM.
- flush_ifid  out  1  load NOP into IF/ID.
- mc_busy  out  1  multi-cycle op in progress.

Behaviour:
- State machine: RUN, MC_BUSY. Down-counter mc_cnt, $clog2(MC_LATENCY+1) bits.
- Reset: state=RUN, mc_cnt=0, all outputs 0 while rst_n low. Reset asserted mid-MC_BUSY aborts the op; state returns to RUN immediately.
- Outputs are combinational from state plus inputs. State and mc_cnt are registered.
- Load-use hazard: in RUN, a hazard exists when all of the following hold:
  - ex_mem_read=1
  - ex_rd != 0
  - (id_use_rs1 and ex_rd==id_rs1) or (id_use_rs2 and ex_rd==id_rs2)
- Load-use response: stall_pc=1, stall_ifid=1, bubble_idex=1, for exactly one cycle. The following cycle EX holds the bubble, so the hazard clears without extra state.
- Redirect: in RUN with ex_redirect=1: flush_ifid=1, bubble_idex=1. Load-use stall is suppressed that cycle because the ID instruction is discarded. The PC is not stalled, so the redirect target loads.
- MC start: in RUN with ex_mc_start=1:
  - next state MC_BUSY, mc_cnt<=MC_LATENCY-2.
  - this cycle: stall_pc, stall_ifid, stall_idex, bubble_exmem all 1.
- MC_BUSY:
  - stall_pc, stall_ifid, stall_idex=1; bubble_exmem=1 while mc_cnt!=0; mc_busy=1.
  - mc_cnt decrements each cycle.
  - In the cycle mc_cnt==0, all stalls deassert and bubble_exmem=0, so the result enters EX/MEM; next state RUN.
  - Total EX occupancy is exactly MC_LATENCY cycles.
- In MC_BUSY, ex_redirect, ex_mc_start and load-use detection are ignored.
- ex_mc_start and ex_redirect in the same RUN cycle: ex_mc_start has priority and ex_redirect is ignored. This is illegal from the decoder and is flagged by a simulation assertion.
- imem_ready=0 in RUN with no other event: stall_pc=1, stall_ifid=1, bubble_idex=1.
- imem_ready=0 combined with other events:
  - with redirect: the flush wins (flush_ifid=1) and the PC is not stalled.
  - with load-use: the outputs are the union of both responses.
- bubble_* and flush_* have priority over stall_* at the register they both target. The controller never asserts stall_idex and bubble_idex together.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds three outputs, each CNT_W bits, reset to 0, wrapping at 2^CNT_W:
  - perf_loaduse_cnt: load-use stall cycles.
  - perf_mc_cnt: MC stall cycles (cycles with stall_idex=1).
  - perf_flush_cnt: redirect events.
- Undefined: ports and counters are absent.

Decomposition:
- Package hazard_pkg holds the state enum hz_state_e {RUN, MC_BUSY}, the REG_ZERO=5'd0 constant, and the stage-control struct typedef.
- Sub-module hazard_perf_counters holds the optional counters, instantiated only under the macro.
- Everything else stays in one module.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5), ID add reads rs2=5 -> one cycle of stall_pc=stall_ifid=bubble_idex=1; all 0 the next cycle.
- Same as above but ex_rd=0, or id_use_rs2=0 -> no stall.
- ex_mc_start pulse, MC_LATENCY=4 -> stall_pc and stall_idex high for 3 cycles; bubble_exmem high for 3 cycles and low on the 4th; mc_busy high for cycles 2-4; RUN on cycle 5.
- ex_redirect with a concurrent load-use match -> flush_ifid=1, bubble_idex=1, stall_pc=0.
- rst_n low in cycle 2 of MC_BUSY -> all outputs 0 at once; state RUN after release; a fresh ex_mc_start restarts the full latency.
- imem_ready=0 for 3 cycles in RUN -> stall_pc=stall_ifid=bubble_idex=1 for exactly 3 cycles. With HAZARD_PERF_CNT_EN, perf counters match the stimulus counts.
